sim_run_ctrl: RTL and testbench

Synthesisable run controller for emulation builds. Sequences the emulated link: reset hold, warm-up, run, drain. Replaces the single hard-wired sim_done with a parametrised multi-channel completion/timeout engine. Sits at top level next to the clock buffer. Drives emu_rst/run_en to datapath blocks and sim_done to the bench or host, which ends the run on its rising edge.

---
 rtl/sim_run_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_sim_run_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sim_run_ctrl.sv
// -----------------------------------------------------------------------------
// sim_run_ctrl
//
// Run controller for emulation builds. Sequences the emulated link through
// reset hold, warm-up, run and drain, then raises a sticky sim_done. The stop
// condition is built from N_CH independent completion channels (ALL or ANY
// mode) with an optional run-cycle limit that ends the run as a timeout.
//
// Ports:
//   clk         in   system clock, all logic on the rising edge
//   rst         in   synchronous active-high reset
//   start       in   run request, sampled only while idle
//   max_cycles  in   run-cycle limit latched on an accepted start (0 = none)
//   ch_done     in   per-channel completion strobes (pulse or level)
//   emu_rst     out  reset to the emulated datapath
//   run_en      out  clock-enable to the emulated datapath
//   cycle_cnt   out  number of run_en cycles so far (saturating)
//   done_mask   out  sticky record of channels that signalled done
//   sim_done    out  sticky end-of-run flag
//   timeout     out  sticky; run ended by the cycle limit, not the channels
//
// Optional build macro SIM_RUN_CTRL_STATUS_EN adds:
//   first_done_cyc out  N_CH slices of CNT_W bits; slice i holds cycle_cnt of
//                       the run cycle in which ch_done[i] was first seen
// -----------------------------------------------------------------------------
module sim_run_ctrl #(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 32,
    parameter int WARMUP_CYC = 16,
    parameter int DRAIN_CYC  = 8,
    parameter int DONE_MODE  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        max_cycles,
    input  logic [N_CH-1:0]         ch_done,
    output logic                    emu_rst,
    output logic                    run_en,
    output logic [CNT_W-1:0]        cycle_cnt,
    output logic [N_CH-1:0]         done_mask,
    output logic                    sim_done,
    output logic                    timeout
`ifdef SIM_RUN_CTRL_STATUS_EN
    ,
    output logic [N_CH*CNT_W-1:0]   first_done_cyc
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WARMUP = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Last phase-counter value of warm-up / drain; unused when the phase is 0.
    localparam logic [31:0] WARM_LAST  = (WARMUP_CYC > 0) ? 32'(WARMUP_CYC - 1) : 32'd0;
    localparam logic [31:0] DRAIN_LAST = (DRAIN_CYC > 0)  ? 32'(DRAIN_CYC - 1)  : 32'd0;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    logic [CNT_W-1:0]   limit_r;
    logic [31:0]        phase_r;

    logic [N_CH-1:0]    eff_s;
    logic               stop_s;
    logic               limit_hit_s;
    logic [CNT_W-1:0]   cnt_inc_s;

    // Completion view: this cycle's strobes count as well as the sticky record.
    always_comb begin
        eff_s = done_mask | ch_done;
        if (DONE_MODE == 1) begin
            stop_s = (eff_s != {N_CH{1'b0}});
        end else begin
            stop_s = (eff_s == {N_CH{1'b1}});
        end
    end

    // Limit check is done one count early so the limit-th run cycle is the last.
    always_comb begin
        if (limit_r != {CNT_W{1'b0}}) begin
            limit_hit_s = (cycle_cnt == (limit_r - CNT_ONE));
        end else begin
            limit_hit_s = 1'b0;
        end
    end

    // Saturating increment of the run-cycle counter.
    always_comb begin
        if (cycle_cnt == {CNT_W{1'b1}}) begin
            cnt_inc_s = cycle_cnt;
        end else begin
            cnt_inc_s = cycle_cnt + CNT_ONE;
        end
    end

    // Run sequencer: state, phase counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            limit_r   <= {CNT_W{1'b0}};
            phase_r   <= 32'd0;
            emu_rst   <= 1'b1;
            run_en    <= 1'b0;
            cycle_cnt <= {CNT_W{1'b0}};
            done_mask <= {N_CH{1'b0}};
            sim_done  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    emu_rst <= 1'b1;
                    run_en  <= 1'b0;
                    if (start) begin
                        limit_r <= max_cycles;
                        phase_r <= 32'd0;
                        if (WARMUP_CYC == 0) begin
                            state_r <= ST_RUN;
                            emu_rst <= 1'b0;
                            run_en  <= 1'b1;
                        end else begin
                            state_r <= ST_WARMUP;
                        end
                    end
                end
                ST_WARMUP: begin
                    if (phase_r == WARM_LAST) begin
                        state_r <= ST_RUN;
                        emu_rst <= 1'b0;
                        run_en  <= 1'b1;
                    end else begin
                        phase_r <= phase_r + 32'd1;
                    end
                end
                ST_RUN: begin
                    cycle_cnt <= cnt_inc_s;
                    done_mask <= eff_s;
                    // Channel completion takes priority over a same-cycle limit hit.
                    if (stop_s || limit_hit_s) begin
                        timeout <= ~stop_s;
                        phase_r <= 32'd0;
                        if (DRAIN_CYC == 0) begin
                            state_r  <= ST_DONE;
                            run_en   <= 1'b0;
                            sim_done <= 1'b1;
                        end else begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    cycle_cnt <= cnt_inc_s;
                    if (phase_r == DRAIN_LAST) begin
                        state_r  <= ST_DONE;
                        run_en   <= 1'b0;
                        sim_done <= 1'b1;
                    end else begin
                        phase_r <= phase_r + 32'd1;
                    end
                end
                ST_DONE: begin
                    // Datapath is frozen out of reset so its state can be read out.
                    emu_rst  <= 1'b0;
                    run_en   <= 1'b0;
                    sim_done <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    emu_rst <= 1'b1;
                    run_en  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SIM_RUN_CTRL_STATUS_EN
    // First-completion timestamps; a clear done_mask bit means "not seen yet".
    always_ff @(posedge clk) begin
        if (rst) begin
            first_done_cyc <= {(N_CH*CNT_W){1'b0}};
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if ((state_r == ST_RUN) && ch_done[i] && !done_mask[i]) begin
                    first_done_cyc[i*CNT_W +: CNT_W] <= cycle_cnt;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_sim_run_ctrl.sv
module tb_sim_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] max_cycles;
    logic [3:0]  ch_done;
    logic        emu_rst;
    logic        run_en;
    logic [31:0] cycle_cnt;
    logic [3:0]  done_mask;
    logic        sim_done;
    logic        timeout;
`ifdef SIM_RUN_CTRL_STATUS_EN
    logic [127:0] first_done_cyc;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sim_run_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .max_cycles (max_cycles),
        .ch_done    (ch_done),
        .emu_rst    (emu_rst),
        .run_en     (run_en),
        .cycle_cnt  (cycle_cnt),
        .done_mask  (done_mask),
        .sim_done   (sim_done),
        .timeout    (timeout)
`ifdef SIM_RUN_CTRL_STATUS_EN
        ,
        .first_done_cyc (first_done_cyc)
`endif
    );

    // One run scenario: limit, cycle_cnt at which each channel pulses (-1 none),
    // and the hand-computed final state.
    typedef struct {
        logic [31:0] max_cyc;
        int          p0;
        int          p1;
        int          p2;
        int          p3;
        logic [31:0] exp_cnt;
        logic [3:0]  exp_mask;
        logic        exp_to;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        start   = 1'b0;
        ch_done = 4'd0;
        tick();
        rst = 1'b0;
    endtask

    // Start pulse sampled at the next edge; max_cycles is then scrambled.
    task automatic start_run(input logic [31:0] max);
        max_cycles = max;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        max_cycles = ~max;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int         pl[4];
        logic [3:0] model;
        logic [3:0] drv;
        int         n;
        pl[0] = v.p0; pl[1] = v.p1; pl[2] = v.p2; pl[3] = v.p3;
        model = 4'd0;
        do_reset();
        start_run(v.max_cyc);
        n = 0;
        while (!sim_done && n < 3000) begin
            drv = 4'd0;
            if (run_en) begin
                for (int c = 0; c < 4; c++) begin
                    if (pl[c] >= 0 && cycle_cnt == 32'(pl[c])) drv[c] = 1'b1;
                end
            end
            ch_done = drv;
            tick();
            model = model | drv;
            ch_done = 4'd0;
            if (run_en || sim_done) check($sformatf("v%0d_mask_step", idx), 64'(done_mask), 64'(model));
            n++;
        end
        check($sformatf("v%0d_sim_done", idx), 64'(sim_done), 64'd1);
        check($sformatf("v%0d_cycle_cnt", idx), 64'(cycle_cnt), 64'(v.exp_cnt));
        check($sformatf("v%0d_done_mask", idx), 64'(done_mask), 64'(v.exp_mask));
        check($sformatf("v%0d_timeout", idx), 64'(timeout), 64'(v.exp_to));
        check($sformatf("v%0d_run_en", idx), 64'(run_en), 64'd0);
        check($sformatf("v%0d_emu_rst", idx), 64'(emu_rst), 64'd0);
`ifdef SIM_RUN_CTRL_STATUS_EN
        for (int c = 0; c < 4; c++) begin
            check($sformatf("v%0d_first_done%0d", idx, c),
                  64'(first_done_cyc[c*32 +: 32]), (pl[c] >= 0) ? 64'(pl[c]) : 64'd0);
        end
`endif
        // DONE is frozen: new strobes and start must change nothing.
        ch_done = 4'hF;
        start   = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        ch_done = 4'd0;
        start   = 1'b0;
        check($sformatf("v%0d_frozen_cnt", idx), 64'(cycle_cnt), 64'(v.exp_cnt));
        check($sformatf("v%0d_frozen_mask", idx), 64'(done_mask), 64'(v.exp_mask));
        check($sformatf("v%0d_frozen_done", idx), 64'(sim_done), 64'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; max_cycles = 32'd0; ch_done = 4'd0;

        // max, p0, p1, p2, p3, cnt, mask, timeout
        vecs[0] = '{32'd100, -1, -1, -1, -1, 32'd108, 4'b0000, 1'b1};
        vecs[1] = '{32'd0,   10, 20, 30, 40, 32'd49,  4'b1111, 1'b0};
        vecs[2] = '{32'd50,  49, 49, 49, 49, 32'd58,  4'b1111, 1'b0};
        vecs[3] = '{32'd5,   -1,  2, -1, -1, 32'd13,  4'b0010, 1'b1};
        vecs[4] = '{32'd1,   -1, -1, -1, -1, 32'd9,   4'b0000, 1'b1};
        vecs[5] = '{32'd0,    0,  0,  0,  0, 32'd9,   4'b1111, 1'b0};

        // Reset values.
        do_reset();
        check("rst_emu_rst", 64'(emu_rst), 64'd1);
        check("rst_run_en", 64'(run_en), 64'd0);
        check("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
        check("rst_done_mask", 64'(done_mask), 64'd0);
        check("rst_sim_done", 64'(sim_done), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);

        // Warm-up length, then limit timeout visible from the first drain cycle.
        start_run(32'd100);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("warm%0d_emu_rst", i), 64'(emu_rst), 64'd1);
            check($sformatf("warm%0d_run_en", i), 64'(run_en), 64'd0);
            if (i < 15) tick();
        end
        tick();
        check("run0_run_en", 64'(run_en), 64'd1);
        check("run0_emu_rst", 64'(emu_rst), 64'd0);
        check("run0_cnt", 64'(cycle_cnt), 64'd0);
        n = 0;
        while (cycle_cnt < 32'd99 && n < 200) begin tick(); n++; end
        check("pre_limit_timeout", 64'(timeout), 64'd0);
        tick();
        check("drain_cnt", 64'(cycle_cnt), 64'd100);
        check("drain_timeout", 64'(timeout), 64'd1);
        check("drain_run_en", 64'(run_en), 64'd1);
        check("drain_sim_done", 64'(sim_done), 64'd0);

        // Table of complete runs.
        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Unlimited run with stray start pulses: never restarts or finishes.
        do_reset();
        start_run(32'd0);
        for (int i = 0; i < 16; i++) tick();
        check("long_run_start_cnt", 64'(cycle_cnt), 64'd0);
        for (int i = 0; i < 1000; i++) begin
            start = (i % 37 == 5) ? 1'b1 : 1'b0;
            tick();
        end
        start = 1'b0;
        check("long_cnt", 64'(cycle_cnt), 64'd1000);
        check("long_run_en", 64'(run_en), 64'd1);
        check("long_emu_rst", 64'(emu_rst), 64'd0);
        check("long_sim_done", 64'(sim_done), 64'd0);

        // Reset in the middle of RUN, then a fresh run from zero.
        do_reset();
        start_run(32'd0);
        ch_done = 4'b0101;
        n = 0;
        while (cycle_cnt != 32'd25 && n < 200) begin tick(); n++; end
        check("mid_reached_25", 64'(cycle_cnt), 64'd25);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ch_done = 4'd0;
        check("mid_rst_emu_rst", 64'(emu_rst), 64'd1);
        check("mid_rst_run_en", 64'(run_en), 64'd0);
        check("mid_rst_cnt", 64'(cycle_cnt), 64'd0);
        check("mid_rst_mask", 64'(done_mask), 64'd0);
        check("mid_rst_sim_done", 64'(sim_done), 64'd0);
        check("mid_rst_timeout", 64'(timeout), 64'd0);
        tick();
        check("mid_idle_hold", 64'(emu_rst), 64'd1);
        start_run(32'd0);
        for (int i = 0; i < 15; i++) tick();
        check("restart_warm_emu_rst", 64'(emu_rst), 64'd1);
        tick();
        check("restart_run_en", 64'(run_en), 64'd1);
        check("restart_cnt0", 64'(cycle_cnt), 64'd0);
        tick();
        check("restart_cnt1", 64'(cycle_cnt), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
